colors_to_bytes: RTL and testbench
==================================

# colors_to_bytes

Packs a stream of 12-bit pixel colors into a bytestream, two colors per three bytes, most-significant nibble first. It is the inverse of `bytes_to_colors`: feeding its output into `bytes_to_colors` reproduces the original colors. It sits on the transmit path between the pixel source (frame buffer or camera reader) and the byte-level stages (`bytes_to_blocks` for encryption, `bytes_to_dibits` for the PHY). The output is read on demand through a `readclk` request, matching the stream_unpack handshake, so it can be driven by `stream_coord`.

## Interface
- `COLOR_LEN`, 12 (from `params.vh`): input word width.
- `BYTE_LEN`, 8 (from `params.vh`): output word width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `inclk`  in  1  `in` is valid this cycle. Honoured only while `rdy` = 1.
- `in`  in  COLOR_LEN  color word.
- `in_done`  in  1  qualifies the current `inclk` word as the last color of the stream.
- `readclk`  in  1  downstream requests a byte this cycle. This is a request, not a clock.
- `outclk`  out  1  `out` is valid and consumed this cycle.
- `out`  out  BYTE_LEN  byte.
- `rdy`  out  1  the block can accept a color this cycle.
- `done`  out  1  pulses together with `outclk` on the last byte of the stream.

## Operation
- Internal storage:
  - 24-bit nibble queue `buf`, oldest nibble at bits [23:20].
  - Nibble count `cnt`, range 0..6.
  - Flag `in_done_found`.
- Byte mapping for colors c0, c1:
  - b0 = c0[11:4]
  - b1 = {c0[3:0], c1[11:8]}
  - b2 = c1[7:0]
- `rdy` = !`in_done_found` && `cnt` <= 3. It is combinational.
- Push (`inclk` && `rdy`): the 3 nibbles of `in` are appended behind the existing `cnt` nibbles, and `cnt` increases by 3.
- Pop (`outclk`): the queue shifts left by 8 bits and `cnt` decreases by 2.
- `outclk` = `readclk` && `cnt` >= 2. `out` = `buf[23:16]`.
- Simultaneous push and pop: the pop shift is applied first, then the append at position `cnt`-2, giving a net `cnt` change of +1.
- End of stream (push with `in_done` = 1):
  - `in_done_found` is set.
  - If the resulting `cnt` is odd, a zero nibble is appended (+1 more), so an odd color count ends with a low nibble of 0.
- `done` = `outclk` && `in_done_found` && `cnt` == 2. In the same cycle `in_done_found` clears and `rdy` is re-enabled for the next stream.
- `in_done` without `inclk` is ignored. An empty stream produces no `done`.
- Protocol violation: `inclk` while `rdy` = 0 drops the word; state is unchanged.
- `rst` clears `cnt`, `buf` and `in_done_found` at any point, including mid-stream; any partially packed data is discarded.

## Timing
- Reset values:
  - `cnt` = 0, `buf` = 0, `in_done_found` = 0.
  - Outputs: `outclk` = 0, `out` = 0, `rdy` = 1, `done` = 0.
- Latency: a color pushed at cycle t can first produce `outclk` at t+1. There is no input-to-output combinational path.
- Throughput: with `readclk` held high, one byte per cycle is sustained. `rdy` toggles so that on average 2 colors are accepted per 3 cycles.
- `outclk`, `out`, `rdy` and `done` depend only on registers plus `readclk`. They are valid combinationally in the cycle the request is made.
- The `cnt` <= 3 bound guarantees no overflow, even with a push in a cycle without a pop.

## Structure
- `COLOR_LEN`, `BYTE_LEN` and the `clog2` helper come from the shared `params.vh` / `util.vh` includes. No new shared constants are added.
- Single module; the nibble queue is inline. No sub-module is warranted.
- A convenience wrapper `colors_to_bytes_coord` may pair it with `stream_coord`, with `downstream_rdy` = `rdy`.

## Test plan
- Colors 0xABC, 0xDEF (`in_done` on the second), `readclk` = 1 → bytes 0xAB, 0xCD, 0xEF; `done` with 0xEF; `rdy` returns to 1 after.
- Single color 0x123 with `in_done` → bytes 0x12, 0x30; `done` with 0x30; no third byte.
- 64 random colors pushed whenever `rdy`, `readclk` random at 50% → byte count 96, `done` exactly once, round-trip through `bytes_to_colors` matches the input.
- Back-to-back streams: 0x111 (`in_done`), then 0x222, 0x333 (`in_done`) → 0x11, 0x10 (done), 0x22, 0x23, 0x33 (done); no bytes mixed across the stream boundary.
- Push 0xFED, read one byte (0xFE), assert `rst` → next cycle `outclk` = 0 with `readclk` = 1, `rdy` = 1; stream 0x456 then yields 0x45, 0x60.
- `inclk` asserted while `rdy` = 0 (`cnt` = 4) with 0x999 → word ignored; output sequence is identical to the run without it.

Source files
------------

// File: rtl/colors_to_bytes_pkg.sv
// Shared widths for the color-to-byte packer.
package colors_to_bytes_pkg;

    localparam int unsigned COLOR_LEN  = 12;
    localparam int unsigned BYTE_LEN   = 8;
    localparam int unsigned NIBBLE_LEN = 4;

    // Nibble queue holds two colors' worth of nibbles.
    localparam int unsigned Q_W       = 2 * COLOR_LEN;
    localparam int unsigned Q_NIBBLES = Q_W / NIBBLE_LEN;

    // Ceiling log2, at least 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

    // Count spans 0..Q_NIBBLES inclusive.
    localparam int unsigned CNT_W = clog2(Q_NIBBLES + 1);

endpackage

// File: rtl/colors_to_bytes.sv
// Packs 12-bit colors into bytes, two colors per three bytes, MS nibble first.
// Bytes are handed out on request (readclk); outputs depend only on state
// plus readclk, so there is no input-to-output combinational path.
module colors_to_bytes
    import colors_to_bytes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inclk,
    input  logic [COLOR_LEN-1:0] in,
    input  logic                 in_done,
    input  logic                 readclk,
    output logic                 outclk,
    output logic [BYTE_LEN-1:0]  out,
    output logic                 rdy,
    output logic                 done
);

    logic [Q_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             found_q, found_d;

    logic             push;
    logic [Q_W-1:0]   buf_popped;
    logic [Q_W-1:0]   buf_ins;
    logic [CNT_W-1:0] cnt_popped;

    // Handshake outputs derived from current state and the read request.
    always_comb begin
        outclk = readclk && (cnt_q >= CNT_W'(2));
        out    = buf_q[Q_W-1 -: BYTE_LEN];
        rdy    = !found_q && (cnt_q <= CNT_W'(3));
        done   = outclk && found_q && (cnt_q == CNT_W'(2));
        push   = inclk && rdy;
    end

    // Next queue state: pop first, then append the new color behind what is left.
    // Bits beyond cnt are always zero, so the append is an OR and the
    // end-of-stream pad nibble needs no explicit write.
    always_comb begin
        buf_popped = outclk ? (buf_q << BYTE_LEN) : buf_q;
        cnt_popped = outclk ? (cnt_q - CNT_W'(2)) : cnt_q;
        // Shift amount is cnt_popped nibbles, i.e. cnt_popped * 4 bits.
        buf_ins    = {in, {(Q_W - COLOR_LEN){1'b0}}} >> {cnt_popped, 2'b00};

        buf_d   = buf_popped;
        cnt_d   = cnt_popped;
        found_d = found_q;

        if (push) begin
            buf_d = buf_popped | buf_ins;
            cnt_d = cnt_popped + CNT_W'(3);
            if (in_done) begin
                found_d = 1'b1;
                if (cnt_d[0]) begin
                    cnt_d = cnt_d + CNT_W'(1);
                end
            end
        end

        // Last byte leaves: re-arm for the next stream.
        if (done) begin
            found_d = 1'b0;
        end
    end

    // State registers with synchronous reset discarding any partial data.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
        end
    end

endmodule

// File: tb/tb_colors_to_bytes.sv
// Self-checking bench for colors_to_bytes using a nibble-FIFO reference model.
module tb_colors_to_bytes;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_inclk;
    logic [11:0] t_in;
    logic        t_in_done;
    logic        t_readclk;
    logic        outclk;
    logic [7:0]  out;
    logic        rdy;
    logic        done;

    int errors = 0;
    int checks = 0;

    colors_to_bytes dut (
        .clk     (clk),
        .rst     (rst),
        .inclk   (t_inclk),
        .in      (t_in),
        .in_done (t_in_done),
        .readclk (t_readclk),
        .outclk  (outclk),
        .out     (out),
        .rdy     (rdy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: plain FIFO of nibbles plus end-of-stream flag.
    logic [3:0] mq[$];
    bit         m_found;

    // Samples of DUT and model for the current cycle.
    logic       s_outclk, s_rdy, s_done;
    logic [7:0] s_out;
    logic       m_outclk, m_rdy, m_done;
    logic [7:0] m_out;

    // Observed byte log for the current scenario.
    logic [7:0] log_b[$];
    int         done_idx[$];

    // One clock cycle: apply inputs, sample mid-cycle, advance the model at the edge.
    task automatic drive(input logic ic, input logic [11:0] c, input logic idn, input logic rc);
        t_inclk   = ic;
        t_in      = c;
        t_in_done = idn;
        t_readclk = rc;
        @(negedge clk);
        s_outclk = outclk;
        s_out    = out;
        s_rdy    = rdy;
        s_done   = done;
        m_outclk = rc && (mq.size() >= 2);
        m_out    = (mq.size() >= 2) ? {mq[0], mq[1]} : 8'h00;
        m_rdy    = !m_found && (mq.size() <= 3);
        m_done   = m_outclk && m_found && (mq.size() == 2);
        if (!rst && s_outclk === 1'b1) log_b.push_back(s_out);
        if (!rst && s_done === 1'b1) done_idx.push_back(log_b.size() - 1);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_found = 0;
        end else begin
            if (m_outclk) begin
                void'(mq.pop_front());
                void'(mq.pop_front());
            end
            if (ic && m_rdy) begin
                mq.push_back(c[11:8]);
                mq.push_back(c[7:4]);
                mq.push_back(c[3:0]);
                if (idn) begin
                    m_found = 1;
                    if (mq.size() % 2 == 1) mq.push_back(4'h0);
                end
            end
            if (m_done) m_found = 0;
        end
        #1;
    endtask

    // Push queued colors (bit 12 = last) whenever rdy, with random reads; checks every cycle.
    task automatic feed(input logic [12:0] items[$], input int unsigned rd_pct, input int unsigned budget);
        bit finished;
        finished = 0;
        for (int unsigned cyc = 0; cyc < budget && !finished; cyc++) begin
            logic ic, rc, idn;
            logic [11:0] c;
            ic  = (items.size() > 0) && (rdy === 1'b1);
            rc  = ($urandom_range(99) < rd_pct);
            c   = ic ? items[0][11:0] : 12'($urandom_range(4095));
            idn = ic ? items[0][12] : ($urandom_range(3) == 0);
            drive(ic, c, idn, rc);
            if (ic) void'(items.pop_front());
            checks++;
            if (s_outclk !== m_outclk) begin
                errors++;
                $display("FAIL feed_outclk cyc=%0d got=%b exp=%b", cyc, s_outclk, m_outclk);
            end
            checks++;
            if (s_rdy !== m_rdy) begin
                errors++;
                $display("FAIL feed_rdy cyc=%0d got=%b exp=%b", cyc, s_rdy, m_rdy);
            end
            checks++;
            if (s_done !== m_done) begin
                errors++;
                $display("FAIL feed_done cyc=%0d got=%b exp=%b", cyc, s_done, m_done);
            end
            if (m_outclk) begin
                checks++;
                if (s_out !== m_out) begin
                    errors++;
                    $display("FAIL feed_out cyc=%0d got=%h exp=%h", cyc, s_out, m_out);
                end
            end
            if (items.size() == 0 && mq.size() == 0 && !m_found) finished = 1;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL feed_timeout got=unfinished exp=drained within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        drive(0, 12'h000, 0, 1);
        checks++;
        if (s_outclk !== 1'b0) begin errors++; $display("FAIL reset_outclk got=%b exp=0", s_outclk); end
        checks++;
        if (s_out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", s_out); end
        checks++;
        if (s_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", s_rdy); end
        checks++;
        if (s_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", s_done); end
    endtask

    task automatic test_pair();
        logic [12:0] items[$];
        logic [7:0]  exp_b[$];
        log_b.delete(); done_idx.delete();
        items = '{13'h0ABC, 13'h1DEF};
        exp_b = '{8'hAB, 8'hCD, 8'hEF};
        feed(items, 100, 20);
        checks++;
        if (log_b.size() != exp_b.size()) begin
            errors++; $display("FAIL pair_count got=%0d exp=%0d", log_b.size(), exp_b.size());
        end else begin
            foreach (exp_b[i]) begin
                checks++;
                if (log_b[i] !== exp_b[i]) begin errors++; $display("FAIL pair_byte%0d got=%h exp=%h", i, log_b[i], exp_b[i]); end
            end
        end
        checks++;
        if (done_idx.size() != 1 || done_idx[0] != 2) begin
            errors++; $display("FAIL pair_done got=%0d pulses exp=1 on byte 2", done_idx.size());
        end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL pair_rdy_after got=%b exp=1", rdy); end
    endtask

    task automatic test_single();
        logic [12:0] items[$];
        log_b.delete(); done_idx.delete();
        items = '{13'h1123};
        feed(items, 100, 20);
        for (int i = 0; i < 3; i++) drive(0, 12'h000, 0, 1);
        checks++;
        if (log_b.size() != 2) begin
            errors++; $display("FAIL single_count got=%0d exp=2", log_b.size());
        end else begin
            checks++;
            if (log_b[0] !== 8'h12) begin errors++; $display("FAIL single_b0 got=%h exp=12", log_b[0]); end
            checks++;
            if (log_b[1] !== 8'h30) begin errors++; $display("FAIL single_b1 got=%h exp=30", log_b[1]); end
        end
        checks++;
        if (done_idx.size() != 1 || done_idx[0] != 1) begin
            errors++; $display("FAIL single_done got=%0d pulses exp=1 on byte 1", done_idx.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] items[$];
        logic [7:0]  exp_b[$];
        log_b.delete(); done_idx.delete();
        items = '{13'h1111, 13'h0222, 13'h1333};
        exp_b = '{8'h11, 8'h10, 8'h22, 8'h23, 8'h33};
        feed(items, 100, 30);
        checks++;
        if (log_b.size() != exp_b.size()) begin
            errors++; $display("FAIL b2b_count got=%0d exp=%0d", log_b.size(), exp_b.size());
        end else begin
            foreach (exp_b[i]) begin
                checks++;
                if (log_b[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, log_b[i], exp_b[i]); end
            end
        end
        checks++;
        if (done_idx.size() != 2 || done_idx[0] != 1 || done_idx[1] != 4) begin
            errors++; $display("FAIL b2b_done got=%0d pulses exp=2 on bytes 1,4", done_idx.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [12:0] items[$];
        log_b.delete(); done_idx.delete();
        drive(1, 12'hFED, 0, 0);
        drive(0, 12'h000, 0, 1);
        checks++;
        if (log_b.size() != 1 || log_b[0] !== 8'hFE) begin
            errors++; $display("FAIL midrst_first got=%0d bytes exp=1 byte FE", log_b.size());
        end
        rst = 1'b1;
        drive(0, 12'h000, 0, 1);
        rst = 1'b0;
        drive(0, 12'h000, 0, 1);
        checks++;
        if (s_outclk !== 1'b0) begin errors++; $display("FAIL midrst_outclk got=%b exp=0", s_outclk); end
        checks++;
        if (s_rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy got=%b exp=1", s_rdy); end
        log_b.delete(); done_idx.delete();
        items = '{13'h1456};
        feed(items, 100, 20);
        checks++;
        if (log_b.size() != 2 || log_b[0] !== 8'h45 || log_b[1] !== 8'h60) begin
            errors++; $display("FAIL midrst_stream got=%0d bytes exp=45,60", log_b.size());
        end
    endtask

    task automatic test_violation();
        logic [12:0] items[$];
        logic [7:0]  exp_b[$];
        log_b.delete(); done_idx.delete();
        drive(1, 12'h123, 0, 0);
        drive(1, 12'h456, 0, 1);
        drive(1, 12'h999, 0, 0);
        checks++;
        if (s_rdy !== 1'b0) begin errors++; $display("FAIL viol_rdy got=%b exp=0", s_rdy); end
        items = '{13'h1789};
        feed(items, 100, 30);
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90};
        checks++;
        if (log_b.size() != exp_b.size()) begin
            errors++; $display("FAIL viol_count got=%0d exp=%0d", log_b.size(), exp_b.size());
        end else begin
            foreach (exp_b[i]) begin
                checks++;
                if (log_b[i] !== exp_b[i]) begin errors++; $display("FAIL viol_byte%0d got=%h exp=%h", i, log_b[i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_random();
        logic [12:0] items[$];
        logic [11:0] cols[$];
        int          mism;
        log_b.delete(); done_idx.delete();
        for (int i = 0; i < 64; i++) begin
            cols.push_back(12'($urandom_range(4095)));
            items.push_back({(i == 63) ? 1'b1 : 1'b0, cols[i]});
        end
        feed(items, 50, 1000);
        checks++;
        if (log_b.size() != 96) begin errors++; $display("FAIL rand_count got=%0d exp=96", log_b.size()); end
        checks++;
        if (done_idx.size() != 1 || done_idx[0] != 95) begin
            errors++; $display("FAIL rand_done got=%0d pulses exp=1 on byte 95", done_idx.size());
        end
        mism = 0;
        for (int p = 0; p < 32 && 3 * p + 2 < log_b.size(); p++) begin
            logic [11:0] c0, c1;
            logic [7:0]  b1;
            b1 = log_b[3 * p + 1];
            c0 = {log_b[3 * p], b1[7:4]};
            c1 = {b1[3:0], log_b[3 * p + 2]};
            if (c0 !== cols[2 * p] || c1 !== cols[2 * p + 1]) mism++;
        end
        checks++;
        if (mism != 0 || log_b.size() != 96) begin
            errors++; $display("FAIL rand_roundtrip got=%0d bad pairs exp=0", mism);
        end
    endtask

    initial begin
        t_inclk = 0; t_in = '0; t_in_done = 0; t_readclk = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 12'h000, 0, 0);
        rst = 1'b0;
        test_reset();
        test_pair();
        test_single();
        test_back_to_back();
        test_mid_reset();
        test_violation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
